// File: rtl/ifid_hazard_ctrl.sv
// IF/ID pipeline sequencing: load-use stalls, branch redirect flushes,
// instruction-memory wait bubbles and saturating stall/flush counters.
module ifid_hazard_ctrl #(
  parameter int FlushCycles = 2,
  parameter int CntWidth    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          id_rs1n,
  input  logic [4:0]          id_rs2n,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic                ex_valid,
  input  logic                ex_is_load,
  input  logic [4:0]          ex_rdn,
  input  logic                br_taken,
  input  logic                imem_ready,
  input  logic                clr_cnt,
  output logic                pc_en,
  output logic                pc_sel,
  output logic                ifid_en,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic [1:0]          state,
  output logic [CntWidth-1:0] stall_cnt,
  output logic [CntWidth-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    IWAIT    = 2'd2
  } state_t;

  localparam int DcWidth = (FlushCycles > 2) ? $clog2(FlushCycles) : 1;
  localparam logic [DcWidth-1:0] DcLoad = DcWidth'(FlushCycles - 1);

  state_t             state_q, state_d;
  logic [DcWidth-1:0] dc_q, dc_d;
  logic               hazard;
  logic               stall_inc;
  logic               flush_inc;

  assign hazard = ex_valid & ex_is_load & (ex_rdn != 5'd0) &
                  ((id_uses_rs1 & (id_rs1n == ex_rdn)) |
                   (id_uses_rs2 & (id_rs2n == ex_rdn)));

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      dc_q    <= dc_d;
    end
  end

  // Clear wins over increment; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    pc_en      = 1'b1;
    pc_sel     = 1'b0;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = state_q;
    dc_d       = dc_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      dc_d       = '0;
    end else if (br_taken) begin
      pc_sel     = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
      if (FlushCycles > 1) begin
        state_d = REDIRECT;
        dc_d    = DcLoad;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        // ID holds a bubble here, so any apparent hazard is ignored.
        REDIRECT: begin
          ifid_flush = 1'b1;
          pc_en      = imem_ready;
          dc_d       = dc_q - DcWidth'(1);
          if (dc_q <= DcWidth'(1)) state_d = RUN;
        end
        RUN, IWAIT: begin
          if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end else if (!imem_ready) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            stall_inc  = 1'b1;
            state_d    = IWAIT;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = RUN;
        end
      endcase
    end
  end

endmodule
